// File: rtl/oram_backend_traffic_gen_pkg.sv
// rtl/oram_backend_traffic_gen_pkg.sv - backend command encodings, FSM states and width helper
package oram_backend_traffic_gen_pkg;

    localparam int BECMDWidth = 2;

    localparam logic [BECMDWidth-1:0] BECMD_Update  = 2'd0;
    localparam logic [BECMDWidth-1:0] BECMD_Append  = 2'd1;
    localparam logic [BECMDWidth-1:0] BECMD_Read    = 2'd2;
    localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_STORE,
        ST_LOAD,
        ST_NEXT,
        ST_FIN
    } state_t;

    // Counter width for values 0..value-1; never narrower than one bit.
    function automatic int log2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/oram_backend_traffic_gen_if.sv
// rtl/oram_backend_traffic_gen_if.sv - backend command/store/load bus between frontend and backend
interface oram_backend_traffic_gen_if #(
    parameter int ORAMU    = 32,
    parameter int ORAML    = 10,
    parameter int FEDWidth = 64
) ();

    logic [oram_backend_traffic_gen_pkg::BECMDWidth-1:0] Command;
    logic [ORAMU-1:0]    PAddr;
    logic [ORAML-1:0]    CurrentLeaf;
    logic [ORAML-1:0]    RemappedLeaf;
    logic                CommandValid;
    logic                CommandReady;
    logic [FEDWidth-1:0] StoreData;
    logic                StoreValid;
    logic                StoreReady;
    logic [FEDWidth-1:0] LoadData;
    logic                LoadValid;
    logic                LoadReady;

    modport master (
        output Command, PAddr, CurrentLeaf, RemappedLeaf, CommandValid,
        input  CommandReady,
        output StoreData, StoreValid,
        input  StoreReady,
        input  LoadData, LoadValid,
        output LoadReady
    );

    modport slave (
        input  Command, PAddr, CurrentLeaf, RemappedLeaf, CommandValid,
        output CommandReady,
        input  StoreData, StoreValid,
        output StoreReady,
        output LoadData, LoadValid,
        input  LoadReady
    );

endinterface

// File: rtl/oram_blk_pattern.sv
// rtl/oram_blk_pattern.sv - block content pattern blk_idx*BlkChunks+chunk_idx, wrapping in FEDWidth
module oram_blk_pattern #(
    parameter int FEDWidth  = 64,
    parameter int BlkChunks = 8,
    parameter int IW        = 7,
    parameter int KW        = 3
) (
    input  logic [IW-1:0]       blk_idx,
    input  logic [KW-1:0]       chunk_idx,
    output logic [FEDWidth-1:0] pattern
);

    assign pattern = FEDWidth'(blk_idx) * FEDWidth'(BlkChunks) + FEDWidth'(chunk_idx);

endmodule

// File: rtl/oram_backend_traffic_gen.sv
// rtl/oram_backend_traffic_gen.sv - four-phase PathORAM backend exerciser with on-chip load checking
module oram_backend_traffic_gen
    import oram_backend_traffic_gen_pkg::*;
#(
    parameter int ORAMU     = 32,
    parameter int ORAML     = 10,
    parameter int FEDWidth  = 64,
    parameter int BlkChunks = 8,
    parameter int NumBlocks = 100
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [15:0] ErrorCount,
    oram_backend_traffic_gen_if.master be
);

    localparam int IW = log2(NumBlocks);
    localparam int KW = log2(BlkChunks);
    localparam logic [IW-1:0]    LAST_BLK   = IW'(NumBlocks - 1);
    localparam logic [KW-1:0]    LAST_CHUNK = KW'(BlkChunks - 1);
    localparam logic [ORAML-1:0] NB_LEAF    = ORAML'(NumBlocks);
    localparam logic [ORAML-1:0] NB2_LEAF   = ORAML'(2 * NumBlocks);

    state_t                  state_q, state_d;
    logic [1:0]              ph_q, ph_d;
    logic [IW-1:0]           i_q, i_d;
    logic [KW-1:0]           k_q, k_d;
    logic [15:0]             err_q, err_d;
    logic                    done_q, done_d;
    logic [BECMDWidth-1:0]   cmd_q, cmd_d;
    logic [ORAMU-1:0]        paddr_q, paddr_d;
    logic [ORAML-1:0]        cur_q, cur_d;
    logic [ORAML-1:0]        rem_q, rem_d;
    logic [ORAML-1:0]        leaf_i;
    logic [FEDWidth-1:0]     pattern;

    oram_blk_pattern #(
        .FEDWidth (FEDWidth),
        .BlkChunks(BlkChunks),
        .IW       (IW),
        .KW       (KW)
    ) u_pattern (
        .blk_idx  (i_q),
        .chunk_idx(k_q),
        .pattern  (pattern)
    );

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        i_d     = i_q;
        k_d     = k_q;
        err_d   = err_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: if (Start) begin
                state_d = ST_CMD;
                ph_d    = 2'd0;
                i_d     = '0;
                k_d     = '0;
                err_d   = 16'd0;
                done_d  = 1'b0;
            end
            ST_CMD: if (be.CommandReady) begin
                k_d     = '0;
                state_d = (ph_q == 2'd0) ? ST_STORE : ST_LOAD;
            end
            ST_STORE: if (be.StoreReady) begin
                k_d = k_q + 1'b1;
                if (k_q == LAST_CHUNK) state_d = ST_NEXT;
            end
            ST_LOAD: if (be.LoadValid) begin
                if (be.LoadData != pattern && err_q != 16'hFFFF) err_d = err_q + 16'd1;
                k_d = k_q + 1'b1;
                if (k_q == LAST_CHUNK) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                state_d = ST_CMD;
                if (i_q == LAST_BLK) begin
                    i_d  = '0;
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command fields are captured once on entry to CMD so they stay frozen through any stall.
    always_comb begin
        cmd_d   = cmd_q;
        paddr_d = paddr_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        leaf_i  = ORAML'(i_d);
        if (state_d == ST_CMD && state_q != ST_CMD) begin
            paddr_d = ORAMU'(i_d);
            case (ph_d)
                2'd0:    begin cmd_d = BECMD_Append;  cur_d = '0;                rem_d = leaf_i;            end
                2'd1:    begin cmd_d = BECMD_Read;    cur_d = leaf_i;            rem_d = NB_LEAF + leaf_i;  end
                2'd2:    begin cmd_d = BECMD_Read;    cur_d = NB_LEAF + leaf_i;  rem_d = NB2_LEAF + leaf_i; end
                default: begin cmd_d = BECMD_ReadRmv; cur_d = NB2_LEAF + leaf_i; rem_d = '0;                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ph_q    <= 2'd0;
            i_q     <= '0;
            k_q     <= '0;
            err_q   <= 16'd0;
            done_q  <= 1'b0;
            cmd_q   <= '0;
            paddr_q <= '0;
            cur_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            i_q     <= i_d;
            k_q     <= k_d;
            err_q   <= err_d;
            done_q  <= done_d;
            cmd_q   <= cmd_d;
            paddr_q <= paddr_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
        end
    end

    assign Busy       = (state_q == ST_CMD) || (state_q == ST_STORE) ||
                        (state_q == ST_LOAD) || (state_q == ST_NEXT);
    assign Done       = done_q;
    assign Pass       = done_q && (err_q == 16'd0);
    assign ErrorCount = err_q;

    assign be.Command      = cmd_q;
    assign be.PAddr        = paddr_q;
    assign be.CurrentLeaf  = cur_q;
    assign be.RemappedLeaf = rem_q;
    assign be.CommandValid = (state_q == ST_CMD);
    assign be.StoreValid   = (state_q == ST_STORE);
    assign be.StoreData    = (state_q == ST_STORE) ? pattern : '0;
    assign be.LoadReady    = (state_q == ST_LOAD);

endmodule

// File: tb/tb_oram_backend_traffic_gen.sv
// tb/tb_oram_backend_traffic_gen.sv - self-checking bench for oram_backend_traffic_gen
module tb_oram_backend_traffic_gen;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] paddr;
        logic [9:0]  cur;
        logic [9:0]  rem;
    } cmd_t;

    typedef struct {
        int   idx;
        cmd_t c;
    } vec_t;

    logic clk;
    logic rst_a, rst_b, start_a, start_b;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] err_a, err_b;
    logic [139:0] outs_a;

    int total, bad;
    int na, ns, nb, sv_drop, cmd_stall, ld_wait, ld_k, ld_idx, pa, st_k, pb, kb;
    logic ld_active, corrupt, store_toggle;
    logic c_fire, s_fire, l_fire;
    vec_t vec_a [16];
    vec_t vec_b [11];
    cmd_t log_a [64];
    cmd_t log_b [2100];
    logic [63:0] store_log [64];
    logic [63:0] mem_a [0:63];
    logic [63:0] mem_b [0:4111];

    oram_backend_traffic_gen_if #(.ORAMU(32), .ORAML(10), .FEDWidth(64)) bus_a ();
    oram_backend_traffic_gen_if #(.ORAMU(32), .ORAML(10), .FEDWidth(64)) bus_b ();

    oram_backend_traffic_gen #(.ORAMU(32), .ORAML(10), .FEDWidth(64), .BlkChunks(8), .NumBlocks(4)) dut_a (
        .Clock(clk), .Reset(rst_a), .Start(start_a), .Busy(busy_a), .Done(done_a),
        .Pass(pass_a), .ErrorCount(err_a), .be(bus_a)
    );

    oram_backend_traffic_gen #(.ORAMU(32), .ORAML(10), .FEDWidth(64), .BlkChunks(8), .NumBlocks(513)) dut_b (
        .Clock(clk), .Reset(rst_b), .Start(start_b), .Busy(busy_b), .Done(done_b),
        .Pass(pass_b), .ErrorCount(err_b), .be(bus_b)
    );

    assign outs_a = {busy_a, done_a, pass_a, err_a, bus_a.Command, bus_a.PAddr, bus_a.CurrentLeaf,
                     bus_a.RemappedLeaf, bus_a.CommandValid, bus_a.StoreData, bus_a.StoreValid,
                     bus_a.LoadReady};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic va(input int n, input int c, input int p, input int cu, input int r);
        vec_a[n].idx = n;
        vec_a[n].c   = '{cmd: 2'(c), paddr: 32'(p), cur: 10'(cu), rem: 10'(r)};
    endtask

    task automatic vb(input int n, input int idx, input int c, input int p, input int cu, input int r);
        vec_b[n].idx = idx;
        vec_b[n].c   = '{cmd: 2'(c), paddr: 32'(p), cur: 10'(cu), rem: 10'(r)};
    endtask

    // Ideal backend A: command/store log, 20-cycle load latency, optional stalls and corruption.
    initial begin
        bus_a.CommandReady = 1'b1; bus_a.StoreReady = 1'b1;
        bus_a.LoadValid = 1'b0; bus_a.LoadData = '0;
        ld_active = 1'b0; ld_wait = 0; ld_k = 0; ld_idx = 0; pa = 0; st_k = 0;
        forever begin
            @(negedge clk);
            c_fire = bus_a.CommandValid && bus_a.CommandReady;
            s_fire = bus_a.StoreValid && bus_a.StoreReady;
            l_fire = bus_a.LoadValid && bus_a.LoadReady;
            if (rst_a) begin
                ld_active = 1'b0; st_k = 0; ld_k = 0;
            end else begin
                if (!bus_a.StoreValid && st_k > 0 && st_k < 8) sv_drop++;
                if (c_fire) begin
                    if (na < 64) log_a[na] = '{bus_a.Command, bus_a.PAddr, bus_a.CurrentLeaf, bus_a.RemappedLeaf};
                    pa = int'(bus_a.PAddr[3:0]);
                    st_k = 0;
                    if (bus_a.Command != 2'd1) begin
                        ld_active = 1'b1; ld_wait = 20; ld_k = 0; ld_idx = na;
                    end
                    na++;
                end
                if (s_fire) begin
                    mem_a[pa*8 + st_k] = bus_a.StoreData;
                    if (ns < 64) store_log[ns] = bus_a.StoreData;
                    ns++; st_k++;
                end
                if (l_fire) begin
                    ld_k++;
                    if (ld_k == 8) ld_active = 1'b0;
                end
                if (ld_active && ld_wait > 0) ld_wait--;
                if (bus_a.CommandValid && cmd_stall > 0) cmd_stall--;
            end
            @(posedge clk); #1;
            bus_a.CommandReady = (cmd_stall == 0);
            bus_a.StoreReady   = store_toggle ? ~bus_a.StoreReady : 1'b1;
            bus_a.LoadValid    = ld_active && (ld_wait == 0);
            bus_a.LoadData     = mem_a[pa*8 + ld_k] ^ ((corrupt && ld_idx == 6 && ld_k == 3) ? 64'd1 : 64'd0);
        end
    end

    // Backend B: always ready, LoadValid held high, data served straight from its store memory.
    initial begin
        bus_b.CommandReady = 1'b1; bus_b.StoreReady = 1'b1;
        bus_b.LoadValid = 1'b1; bus_b.LoadData = '0;
        nb = 0; pb = 0; kb = 0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                if (bus_b.CommandValid) begin
                    if (nb < 2100) log_b[nb] = '{bus_b.Command, bus_b.PAddr, bus_b.CurrentLeaf, bus_b.RemappedLeaf};
                    nb++;
                    pb = int'(bus_b.PAddr[9:0]);
                    kb = 0;
                end else if (bus_b.StoreValid) begin
                    mem_b[pb*8 + kb] = bus_b.StoreData;
                    kb++;
                end else if (bus_b.LoadReady) begin
                    kb++;
                end
            end
            @(posedge clk); #1;
            bus_b.LoadData = mem_b[pb*8 + kb];
        end
    end

    task automatic start_run_a();
        @(posedge clk); #1;
        na = 0; ns = 0; sv_drop = 0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!done_a && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(name, done_a, 1'b1);
    endtask

    task automatic check_cmds_a(input string tag);
        chk({tag, "_cmd_count"}, na, 16);
        for (int n = 0; n < 16; n++)
            chk($sformatf("%s_cmd%0d", tag, vec_a[n].idx), log_a[vec_a[n].idx], vec_a[n].c);
    endtask

    task automatic check_stores_a(input string tag);
        chk({tag, "_store_count"}, ns, 32);
        for (int n = 0; n < 32; n++)
            chk($sformatf("%s_store%0d", tag, n), store_log[n], 64'(n));
    endtask

    initial begin
        cmd_t snap;
        int   unstable;
        int   n;
        total = 0; bad = 0; na = 0; ns = 0; sv_drop = 0; cmd_stall = 0;
        corrupt = 1'b0; store_toggle = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;

        va(0, 1, 0, 0, 0);  va(1, 1, 1, 0, 1);  va(2, 1, 2, 0, 2);   va(3, 1, 3, 0, 3);
        va(4, 2, 0, 0, 4);  va(5, 2, 1, 1, 5);  va(6, 2, 2, 2, 6);   va(7, 2, 3, 3, 7);
        va(8, 2, 0, 4, 8);  va(9, 2, 1, 5, 9);  va(10, 2, 2, 6, 10); va(11, 2, 3, 7, 11);
        va(12, 3, 0, 8, 0); va(13, 3, 1, 9, 0); va(14, 3, 2, 10, 0); va(15, 3, 3, 11, 0);
        vb(0, 0, 1, 0, 0, 0);          vb(1, 512, 1, 512, 0, 512);
        vb(2, 513, 2, 0, 0, 513);      vb(3, 1024, 2, 511, 511, 0);
        vb(4, 1025, 2, 512, 512, 1);   vb(5, 1026, 2, 0, 513, 2);
        vb(6, 1536, 2, 510, 1023, 512); vb(7, 1537, 2, 511, 0, 513);
        vb(8, 1538, 2, 512, 1, 514);   vb(9, 1539, 3, 0, 2, 0);
        vb(10, 2051, 3, 512, 514, 0);

        repeat (3) @(posedge clk); #1;
        chk("reset_outs_zero", outs_a == '0, 1'b1);
        chk("reset_busy_b", busy_b, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;

        // Run 1: ideal backend, with a Start pulse while busy that must be ignored.
        start_run_a();
        chk("busy_after_start", busy_a, 1'b1);
        repeat (30) @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done_a("run1_done");
        check_cmds_a("run1");
        check_stores_a("run1");
        chk("run1_pass", pass_a, 1'b1);
        chk("run1_err", err_a, 0);
        chk("run1_busy", busy_a, 1'b0);

        // Run 2: chunk 3 of block 2 corrupted during Ph1.
        corrupt = 1'b1;
        start_run_a();
        chk("run2_done_cleared", done_a, 1'b0);
        wait_done_a("run2_done");
        chk("run2_err", err_a, 1);
        chk("run2_pass", pass_a, 1'b0);
        corrupt = 1'b0;

        // Run 3: first command stalled 50 cycles, StoreReady toggling every cycle.
        cmd_stall = 50;
        store_toggle = 1'b1;
        start_run_a();
        n = 0;
        @(negedge clk);
        while (!bus_a.CommandValid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("run3_cmd_valid", bus_a.CommandValid, 1'b1);
        snap = '{bus_a.Command, bus_a.PAddr, bus_a.CurrentLeaf, bus_a.RemappedLeaf};
        unstable = 0;
        repeat (40) begin
            @(negedge clk);
            if (!bus_a.CommandValid ||
                snap != '{bus_a.Command, bus_a.PAddr, bus_a.CurrentLeaf, bus_a.RemappedLeaf})
                unstable++;
        end
        #1;
        chk("run3_stall_stable", unstable, 0);
        chk("run3_none_accepted", na, 0);
        wait_done_a("run3_done");
        check_cmds_a("run3");
        check_stores_a("run3");
        chk("run3_storevalid_drop", sv_drop, 0);
        chk("run3_pass", pass_a, 1'b1);
        store_toggle = 1'b0;

        // Run 4: reset while storing block 1, then restart from scratch.
        start_run_a();
        n = 0;
        @(negedge clk);
        while (ns < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("run4_in_store_blk1", (ns >= 10) && (ns < 16) && bus_a.StoreValid, 1'b1);
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        chk("run4_reset_outs_zero", outs_a == '0, 1'b1);
        rst_a = 1'b0;
        @(posedge clk); #1;
        chk("run4_idle_after_reset", outs_a == '0, 1'b1);
        start_run_a();
        wait_done_a("run4_done");
        chk("run4_first_cmd", log_a[0], vec_a[0].c);
        check_cmds_a("run4");
        chk("run4_pass", pass_a, 1'b1);

        // Instance B: 513 blocks, leaf arithmetic wraps mod 1024.
        n = 0;
        @(negedge clk);
        while (!done_b && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("b_done", done_b, 1'b1);
        chk("b_cmd_count", nb, 2052);
        for (int v = 0; v < 11; v++)
            chk($sformatf("b_cmd%0d", vec_b[v].idx), log_b[vec_b[v].idx], vec_b[v].c);
        chk("b_store_0_5", mem_b[5], 64'd5);
        chk("b_store_512_7", mem_b[4103], 64'd4103);
        chk("b_err", err_b, 0);
        chk("b_pass", pass_b, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
